// File: rtl/aes_round_sched.sv
// aes_round_sched: sequences one AES-128 encryption at a time.
//
// A key load pulses the key-expansion engine's reset, then holds its start
// level until its finish flag is seen, then copies the expanded schedule into
// a local round-key store. Each accepted plaintext block gets the initial
// AddRoundKey, then makes NR passes through an external single-round datapath.
// The ciphertext is held on a valid/ready port until it is taken.
//
// Ports:
//   clk, rst               clock (posedge) and synchronous active-high reset
//   key_load, key_in       key load request (honoured while key_ready) and key
//   key_ready, key_valid   load acceptable / complete schedule stored
//   ks_rst, ks_start       reset pulse and start level to the key-expansion engine
//   ks_key                 latched key driven to the key-expansion engine
//   ks_done, ks_words      engine finish flag (level) and expanded schedule
//   blk_valid/ready/in     plaintext input handshake
//   dp_state, dp_rk        state and round key driven to the round datapath
//   dp_last                final round: the datapath skips MixColumns
//   dp_result              combinational round output from the datapath
//   rnd_idx                current round 1..NR, 0 outside the round loop
//   out_valid/ready/data   ciphertext output handshake
//
// Only NR = 10 (AES-128) is supported.

module aes_round_sched #(
    parameter int unsigned NR    = 10,
    parameter int unsigned BLK_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_load,
    input  logic [BLK_W-1:0]          key_in,
    output logic                      key_ready,
    output logic                      key_valid,
    output logic                      ks_rst,
    output logic                      ks_start,
    output logic [BLK_W-1:0]          ks_key,
    input  logic                      ks_done,
    input  logic [BLK_W*(NR+1)-1:0]   ks_words,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [BLK_W-1:0]          blk_in,
    output logic [BLK_W-1:0]          dp_state,
    output logic [BLK_W-1:0]          dp_rk,
    output logic                      dp_last,
    input  logic [BLK_W-1:0]          dp_result,
    output logic [3:0]                rnd_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BLK_W-1:0]          out_data
);

    localparam logic [3:0] LastRnd = 4'(NR);

    typedef enum logic [2:0] {
        StIdle,
        StKsRst,
        StKsWait,
        StReady,
        StRound,
        StOut
    } state_e;

    state_e fsm_q;

    logic                     key_ready_q;
    logic                     key_valid_q;
    logic                     ks_rst_q;
    logic                     ks_start_q;
    logic [BLK_W-1:0]         ks_key_q;
    logic [BLK_W-1:0]         state_q;
    logic [3:0]               rnd_q;
    logic [BLK_W-1:0]         dp_rk_q;
    logic                     dp_last_q;
    logic                     out_valid_q;

    // Packed store copied straight from ks_words: element NR holds round key 0
    // (the top slice), so round key r lives at rk_q[NR - r].
    logic [NR:0][BLK_W-1:0]   rk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= StIdle;
            key_ready_q <= 1'b1;
            key_valid_q <= 1'b0;
            ks_rst_q    <= 1'b0;
            ks_start_q  <= 1'b0;
            ks_key_q    <= '0;
            state_q     <= '0;
            rnd_q       <= '0;
            dp_rk_q     <= '0;
            dp_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rk_q        <= '0;
        end else begin
            unique case (fsm_q)
                StIdle, StReady: begin
                    if (key_load) begin
                        // A key load always wins over a pending block.
                        ks_key_q    <= key_in;
                        key_valid_q <= 1'b0;
                        key_ready_q <= 1'b0;
                        ks_rst_q    <= 1'b1;
                        fsm_q       <= StKsRst;
                    end else if (fsm_q == StReady && blk_valid) begin
                        state_q     <= blk_in ^ rk_q[NR];
                        rnd_q       <= 4'd1;
                        dp_rk_q     <= rk_q[LastRnd - 4'd1];
                        dp_last_q   <= (LastRnd == 4'd1);
                        key_ready_q <= 1'b0;
                        fsm_q       <= StRound;
                    end
                end

                StKsRst: begin
                    // ks_done is not looked at here: it may still be the
                    // previous load's flag.
                    ks_rst_q   <= 1'b0;
                    ks_start_q <= 1'b1;
                    fsm_q      <= StKsWait;
                end

                StKsWait: begin
                    if (ks_done) begin
                        rk_q        <= ks_words;
                        key_valid_q <= 1'b1;
                        ks_start_q  <= 1'b0;
                        key_ready_q <= 1'b1;
                        fsm_q       <= StReady;
                    end
                end

                StRound: begin
                    state_q <= dp_result;
                    if (rnd_q == LastRnd) begin
                        rnd_q       <= '0;
                        dp_rk_q     <= '0;
                        dp_last_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= StOut;
                    end else begin
                        rnd_q     <= rnd_q + 4'd1;
                        dp_rk_q   <= rk_q[LastRnd - (rnd_q + 4'd1)];
                        dp_last_q <= ((rnd_q + 4'd1) == LastRnd);
                    end
                end

                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        key_ready_q <= 1'b1;
                        fsm_q       <= StReady;
                    end
                end

                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

    // Combinational so that a same-cycle key_load blocks the block handshake.
    assign blk_ready = (fsm_q == StReady) && !key_load;

    assign key_ready = key_ready_q;
    assign key_valid = key_valid_q;
    assign ks_rst    = ks_rst_q;
    assign ks_start  = ks_start_q;
    assign ks_key    = ks_key_q;
    assign dp_state  = state_q;
    assign dp_rk     = dp_rk_q;
    assign dp_last   = dp_last_q;
    assign rnd_idx   = rnd_q;
    assign out_valid = out_valid_q;
    assign out_data  = state_q;

endmodule
